// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin arbiter/sequencer sharing one UART TX FIFO between N_REQ
//   requesters. A granted 16-bit word is latched and written into the FIFO
//   as two bytes, MSB first then LSB, matching the {MSB, LSB} framing the
//   UART RX side reassembles.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low (0 = reset)
//   req_valid  in   [N_REQ]     bit i: requester i has a word ready
//   req_data   in   [16*N_REQ]  word of requester i at [i*16 +: 16]
//   req_ready  out  [N_REQ]     one-cycle accept pulse for the granted requester
//   tx_full    in   TX FIFO full flag
//   wr_uart    out  one-cycle write strobe into the TX FIFO
//   w_data     out  [8]         byte written while wr_uart=1
//   grant_id   out  [ID_W]      requester whose word is being sent
//   busy       out  high whenever the sequencer is not idle (decoded from state)
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_MSB = 2'd1,
    ST_SEND_LSB = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [N_REQ-1:0]    req_ready_q, req_ready_d;
  logic                wr_uart_q, wr_uart_d;
  logic [BYTE_W-1:0]   w_data_q, w_data_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [WORD_W-1:0]   win_data;
  int unsigned         cand;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req_valid[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  // Word of the winning requester.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_data = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    wr_uart_d   = 1'b0;
    w_data_d    = w_data_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          hold_d      = win_data;
          grant_id_d  = win_idx;
          req_ready_d = N_REQ'(1) << win_idx;
          state_d     = ST_SEND_MSB;
        end
      end

      // The !wr_uart_q guard leaves a gap cycle so tx_full reflects the last write.
      ST_SEND_MSB: begin
        if (!tx_full && !wr_uart_q) begin
          wr_uart_d = 1'b1;
          w_data_d  = hold_q[15:8];
          state_d   = ST_SEND_LSB;
        end
      end

      ST_SEND_LSB: begin
        if (!tx_full && !wr_uart_q) begin
          wr_uart_d = 1'b1;
          w_data_d  = hold_q[7:0];
          rr_ptr_d  = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      wr_uart_q   <= 1'b0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      wr_uart_q   <= wr_uart_d;
      w_data_q    <= w_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_uart   = wr_uart_q;
  assign w_data    = w_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
